// File: rtl/tile_spawner.sv
// Writes a 2 (or 4 with TILE_SPAWN_FOUR_EN) into a pseudo-randomly chosen empty cell of a 4x4 board.
// Latency 2 edges (full board) up to 34 edges; start is only sampled in IDLE and ignored while busy.
module tile_spawner #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [3:0][3:0][11:0] matrix_in_i,
    output logic [3:0][3:0][11:0] matrix_out_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  full_o
);

    localparam logic [15:0] SEED_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [2:0] {IDLE, COUNT, REDUCE, SCAN, DONE} state_t;

    state_t            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [15:0][11:0] work_q, work_d;
    logic [15:0][11:0] out_q, out_d;
    logic              full_q, full_d;
    logic [4:0]        empty_cnt_q, empty_cnt_d;
    logic [3:0]        k_q, k_d;
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        seen_q, seen_d;

    logic [4:0]        empty_now;
    logic [11:0]       tile_val;
    logic [15:0][11:0] write_val;

    always_comb begin
        empty_now = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (work_q[i] == 12'd0) begin
                empty_now = empty_now + 5'd1;
            end
        end
    end

`ifdef TILE_SPAWN_FOUR_EN
    assign tile_val = (lfsr_q[10:8] == 3'b000) ? 12'd4 : 12'd2;
`else
    assign tile_val = 12'd2;
`endif

    always_comb begin
        state_d     = state_q;
        lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
        work_d      = work_q;
        out_d       = out_q;
        full_d      = full_q;
        empty_cnt_d = empty_cnt_q;
        k_d         = k_q;
        idx_d       = idx_q;
        seen_d      = seen_q;
        write_val   = work_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    work_d  = matrix_in_i;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                empty_cnt_d = empty_now;
                if (empty_now == 5'd0) begin
                    out_d   = work_q;
                    full_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    k_d     = lfsr_q[3:0];
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                // Repeated subtraction gives k mod empty_cnt; empty_cnt==16 never subtracts.
                if ({1'b0, k_q} >= empty_cnt_q) begin
                    k_d = k_q - empty_cnt_q[3:0];
                end else begin
                    idx_d   = 4'd0;
                    seen_d  = 4'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (work_q[idx_q] == 12'd0) begin
                    if (seen_q == k_q) begin
                        write_val[idx_q] = tile_val;
                        work_d  = write_val;
                        out_d   = write_val;
                        full_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        seen_d = seen_q + 4'd1;
                    end
                end
                idx_d = idx_q + 4'd1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED_INIT;
            work_q      <= '0;
            out_q       <= '0;
            full_q      <= 1'b0;
            empty_cnt_q <= 5'd0;
            k_q         <= 4'd0;
            idx_q       <= 4'd0;
            seen_q      <= 4'd0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            work_q      <= work_d;
            out_q       <= out_d;
            full_q      <= full_d;
            empty_cnt_q <= empty_cnt_d;
            k_q         <= k_d;
            idx_q       <= idx_d;
            seen_q      <= seen_d;
        end
    end

    assign matrix_out_o = out_q;
    assign full_o       = full_q;
    assign done_o       = (state_q == DONE);
    assign busy_o       = (state_q != IDLE);

endmodule

// File: doc/tile_spawner.md
# tile_spawner

Game-logic stage directly downstream of the `sum`/movement path in the 2048 datapath. After a move has been summed and compacted, this block takes the resulting 4x4 board. It selects one empty cell pseudo-randomly with an internal LFSR, writes a new tile (2, or optionally 4) into that cell, and hands the board on with a one-cycle `done` pulse. If the board has no empty cell, it reports `full` and returns the board unchanged, so the game-over check can use it.

## Interface
- `SEED`, default 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.
- `clk`  in  1  single system clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request a spawn; sampled only in IDLE.
- `matrix_in`  in  [11:0] x [3:0][3:0]  board after movement; [row][col], literal tile values, 0 = empty.
- `matrix_out`  out  [11:0] x [3:0][3:0]  board with the new tile; registered.
- `done`  out  1  single-cycle pulse; `matrix_out` and `full` are valid from this cycle.
- `busy`  out  1  high in every state except IDLE.
- `full`  out  1  registered with `done`; 1 = no empty cell, nothing written.

## Operation
- Linear cell index is row*4+col, range 0..15. Scan order is row-major, starting at index 0.
- LFSR: 16-bit Galois, mask 16'hB400, shifts right.
  - It advances every cycle in every state, including IDLE.
  - It is never reloaded except by reset.
- FSM states: IDLE, COUNT, REDUCE, SCAN, DONE.
  - IDLE: on `start`=1, latch `matrix_in` into the working register and go to COUNT. While busy, `start` is ignored.
  - COUNT: compute `empty_cnt` (5-bit, 0..16) as the number of zero cells in the working register.
    - If `empty_cnt`=0, go to DONE with full=1.
    - Otherwise set k = lfsr[3:0] and go to REDUCE.
  - REDUCE: if k >= `empty_cnt`, set k = k - `empty_cnt` and stay. Otherwise clear idx and `seen`, then go to SCAN. This yields k mod `empty_cnt` without a divider.
  - SCAN: examine cell idx once per cycle.
    - If the cell is empty and `seen`==k, write the tile value, set full=0 and go to DONE.
    - Else, if the cell is empty, increment `seen`. In both cases increment idx.
  - DONE: copy the working register to `matrix_out` on entry. `done`=1 for this one cycle. Return to IDLE.
- Tile value is 12'd2 unless the configuration below selects 12'd4.
- Non-empty cells pass through bit-exact. Exactly one cell changes when full=0; none change when full=1.
- Reset values: `matrix_out` all 12'd0, `done`=0, `busy`=0, `full`=0, FSM=IDLE, LFSR=SEED.
- Reset mid-operation:
  - The FSM aborts to IDLE and no `done` is issued.
  - `matrix_out` is cleared to 0.
  - The working register contents are don't-care.

## Timing
- Edge E0 samples `start`; `busy` is high from the cycle after E0.
- Full board: `done` is high after 2 edges, i.e. E0 and the COUNT edge.
- General case: `done` is high after nsub + s + 4 edges from E0, where:
  - nsub = number of REDUCE subtractions (0..15);
  - s = linear index of the chosen cell.
- Worst case is 34 cycles.
- `done` and the updated `matrix_out`/`full` appear in the same cycle.
  - `matrix_out` holds its value until the next DONE or reset.
  - `full` holds its value until the next DONE or reset.
- `start` is accepted again in the cycle after `done`, because the FSM is back in IDLE. Back-to-back requests are therefore one request per completion.
- `start` is level-sampled. If it is held high, a new spawn begins on the cycle after `done`.

## Configuration
- `TILE_SPAWN_FOUR_EN` defined:
  - At the write cycle in SCAN, value = 12'd4 if lfsr[10:8]==3'b000, else 12'd2.
  - This gives about a 1/8 chance of a 4.
- `TILE_SPAWN_FOUR_EN` undefined: value is always 12'd2, and lfsr[10:8] is unused.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles. Required: `matrix_out` all 0, `done`/`busy`/`full`=0; after release, no `done` without `start`.
- Full board: every cell 12'd8, pulse `start`. Required: `done` after 2 edges, `full`=1, `matrix_out` all 8, `busy` low the cycle after.
- Single empty cell: all cells 12'd2 except [2][1]=0, pulse `start`. Required:
  - [2][1]=2 (macro off), all other cells unchanged, `full`=0;
  - `done` within 34 cycles, exactly one pulse.
- Empty board over 1000 runs with random start spacing. Required:
  - exactly one nonzero cell per run, valued 2 or 4;
  - all 16 positions hit;
  - with the macro on, the count of 4s is within 60..190; with it off, zero 4s.
- `start` pulsed while busy, then `rst_n` low during SCAN. Required: the extra `start` is ignored; reset gives IDLE, no `done`, `matrix_out`=0, and a following `start` completes normally.
